// File: rtl/background_redraw_if.sv
// Bus between the background redraw engine, the game-state controller,
// the background ROMs and the VGA adapter write port.
interface background_redraw_if #(
  parameter int unsigned ADDR_W   = 17,
  parameter int unsigned COLOUR_W = 3
);
  logic [3:0]          gameState;
  logic [COLOUR_W-1:0] romData;
  logic [ADDR_W-1:0]   romAddr;
  logic [2:0]          romSel;
  logic [8:0]          x;
  logic [7:0]          y;
  logic [COLOUR_W-1:0] colour;
  logic                writeEn;
  logic                doneRedraw;

  // master: the redraw engine; slave: controller, ROMs and VGA adapter
  modport master (
    input  gameState, romData,
    output romAddr, romSel, x, y, colour, writeEn, doneRedraw
  );

  modport slave (
    output gameState, romData,
    input  romAddr, romSel, x, y, colour, writeEn, doneRedraw
  );
endinterface

// File: rtl/background_redraw.sv
// Framebuffer redraw engine: sweeps the screen once per redraw request, streaming ROM pixels to the VGA port.
// Optional macro REDRAW_SKIP_KEY_EN suppresses writes of pixels equal to KEY_COLOUR.
module background_redraw #(
  parameter int unsigned         WIDTH      = 320,
  parameter int unsigned         HEIGHT     = 240,
  parameter int unsigned         ADDR_W     = 17,
  parameter int unsigned         COLOUR_W   = 3,
  parameter logic [COLOUR_W-1:0] KEY_COLOUR = '0
) (
  input logic             clock,
  input logic             resetn,
  background_redraw_if.master bus
);

  localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t              state;
  logic [8:0]          cx;
  logic [7:0]          cy;
  logic [ADDR_W-1:0]   addr_q;
  logic [8:0]          x_q;
  logic [7:0]          y_q;
  logic [2:0]          sel_q;
  logic [3:0]          req_q;
  logic                plot_q;
  logic                done_q;

  logic                is_redraw;
  logic [2:0]          new_sel;
  logic                restart;
  logic                last_pt;

  // Redraw code decode and image select
  always_comb begin
    is_redraw = 1'b1;
    new_sel   = 3'd0;
    case (bus.gameState)
      4'd10:   new_sel = 3'd0;
      4'd1:    new_sel = 3'd1;
      4'd3:    new_sel = 3'd2;
      4'd5:    new_sel = 3'd3;
      4'd7:    new_sel = 3'd4;
      default: is_redraw = 1'b0;
    endcase
  end

  assign restart = is_redraw && (bus.gameState != req_q);
  assign last_pt = (cx == X_LAST) && (cy == Y_LAST);

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= IDLE;
      cx     <= '0;
      cy     <= '0;
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
      sel_q  <= '0;
      req_q  <= '0;
      plot_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      plot_q <= 1'b0;
      case (state)
        IDLE: begin
          if (is_redraw) begin
            state  <= SCAN;
            req_q  <= bus.gameState;
            sel_q  <= new_sel;
            cx     <= '0;
            cy     <= '0;
            addr_q <= '0;
          end
        end
        SCAN, DRAIN: begin
          // The address issued this cycle is plotted next cycle, even across a restart
          if (state == SCAN) begin
            plot_q <= 1'b1;
            x_q    <= cx;
            y_q    <= cy;
          end
          if (restart) begin
            state  <= SCAN;
            req_q  <= bus.gameState;
            sel_q  <= new_sel;
            cx     <= '0;
            cy     <= '0;
            addr_q <= '0;
          end else if (state == DRAIN) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else if (last_pt) begin
            state <= DRAIN;
          end else begin
            if (cx == X_LAST) begin
              cx <= '0;
              cy <= cy + 8'd1;
            end else begin
              cx <= cx + 9'd1;
            end
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        DONE: begin
          if (bus.gameState != req_q) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.romAddr    = addr_q;
  assign bus.romSel     = sel_q;
  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.doneRedraw = done_q;
  assign bus.colour     = plot_q ? bus.romData : '0;

`ifdef REDRAW_SKIP_KEY_EN
  assign bus.writeEn = plot_q && (bus.romData != KEY_COLOUR);
`else
  logic unused_key;
  assign unused_key  = ^KEY_COLOUR;
  assign bus.writeEn = plot_q;
`endif

endmodule

// File: tb/tb_background_redraw.sv
// Directed bench for background_redraw on a 4x2 screen; the ROM model returns the previous cycle's address.
module tb_background_redraw;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned AW = 3;
  localparam int unsigned CW = 3;
`ifdef REDRAW_SKIP_KEY_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  background_redraw_if #(.ADDR_W(AW), .COLOUR_W(CW)) bus ();

  background_redraw #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .COLOUR_W(CW), .KEY_COLOUR(3'd0)
  ) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // Registered ROM: data for an address appears the following cycle
  logic [2:0] rom_q;
  always @(posedge clock) rom_q <= bus.romAddr;
  assign bus.romData = rom_q;

  int n_vec = 0;
  int n_err = 0;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".romAddr"}, 32'(bus.romAddr), 0);
    chk({tag, ".romSel"},  32'(bus.romSel), 0);
    chk({tag, ".x"},       32'(bus.x), 0);
    chk({tag, ".y"},       32'(bus.y), 0);
    chk({tag, ".colour"},  32'(bus.colour), 0);
    chk({tag, ".writeEn"}, 32'(bus.writeEn), 0);
    chk({tag, ".done"},    32'(bus.doneRedraw), 0);
  endtask

  // Called one cycle after the edge that started the sweep; checks all 8 plots and done
  task automatic sweep(input string tag, input logic [2:0] sel);
    int writes;
    writes = 0;
    for (int s = 0; s < 8; s++) begin
      tick;
      chk({tag, ".we"},     32'(bus.writeEn), (SKIP && s == 0) ? 0 : 1);
      chk({tag, ".x"},      32'(bus.x), s % 4);
      chk({tag, ".y"},      32'(bus.y), s / 4);
      chk({tag, ".colour"}, 32'(bus.colour), s);
      chk({tag, ".sel"},    32'(bus.romSel), 32'(sel));
      chk({tag, ".done"},   32'(bus.doneRedraw), 0);
      writes += int'(bus.writeEn);
    end
    chk({tag, ".writes"}, writes, SKIP ? 7 : 8);
    tick;
    chk({tag, ".done_hi"}, 32'(bus.doneRedraw), 1);
    chk({tag, ".we_lo"},   32'(bus.writeEn), 0);
  endtask

  initial begin
    resetn        = 1'b0;
    bus.gameState = 4'd0;
    tick;
    tick;
    chk_all_zero("reset");

    // Initial draw: trigger on code 10
    resetn        = 1'b1;
    bus.gameState = 4'd10;
    tick;
    chk("init.addr0", 32'(bus.romAddr), 0);
    chk("init.we0",   32'(bus.writeEn), 0);
    sweep("init", 3'd0);
    tick;
    tick;
    chk("init.hold_done", 32'(bus.doneRedraw), 1);
    chk("init.hold_we",   32'(bus.writeEn), 0);
    chk("init.addr_max",  32'(bus.romAddr), 7);
    bus.gameState = 4'd0;
    tick;
    chk("init.release", 32'(bus.doneRedraw), 0);

    // Bridge 1 held after done: no retrigger, then non-redraw code releases done
    bus.gameState = 4'd1;
    tick;
    chk("b1.sel",   32'(bus.romSel), 1);
    chk("b1.addr0", 32'(bus.romAddr), 0);
    sweep("b1", 3'd1);
    repeat (3) tick;
    chk("b1.hold_done", 32'(bus.doneRedraw), 1);
    chk("b1.hold_we",   32'(bus.writeEn), 0);
    bus.gameState = 4'd2;
    tick;
    chk("b1.release", 32'(bus.doneRedraw), 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("b1.idle_we",   32'(bus.writeEn), 0);
      chk("b1.idle_done", 32'(bus.doneRedraw), 0);
    end

    // Abort: switch to bridge 2 during the 4th scan cycle
    bus.gameState = 4'd1;
    tick;
    tick;
    tick;
    tick;
    chk("abort.addr3", 32'(bus.romAddr), 3);
    bus.gameState = 4'd3;
    tick;
    chk("abort.inflight_we", 32'(bus.writeEn), 1);
    chk("abort.inflight_x",  32'(bus.x), 3);
    chk("abort.inflight_y",  32'(bus.y), 0);
    chk("abort.inflight_c",  32'(bus.colour), 3);
    chk("abort.new_sel",     32'(bus.romSel), 2);
    chk("abort.addr0",       32'(bus.romAddr), 0);
    sweep("abort", 3'd2);
    bus.gameState = 4'd0;
    tick;
    chk("abort.release", 32'(bus.doneRedraw), 0);

    // Reset mid-sweep at pixel 5, then restart with code 10 held
    bus.gameState = 4'd10;
    tick;
    repeat (5) tick;
    chk("rst.pre_we",   32'(bus.writeEn), 1);
    chk("rst.pre_x",    32'(bus.x), 0);
    chk("rst.pre_y",    32'(bus.y), 1);
    chk("rst.pre_addr", 32'(bus.romAddr), 5);
    resetn = 1'b0;
    tick;
    chk_all_zero("rst.mid");
    resetn = 1'b1;
    tick;
    chk("rst.addr0", 32'(bus.romAddr), 0);
    chk("rst.we0",   32'(bus.writeEn), 0);
    sweep("rst", 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/background_redraw.md
# background_redraw

Framebuffer redraw engine that executes the redraw requests issued by the game-state controller. When the game state enters a redraw state, the block sweeps the whole screen once and streams each background pixel from the selected image ROM to the VGA adapter's write port. When the sweep is complete, it raises `doneRedraw`. It sits between the game-state controller, which consumes `doneRedraw`, and the VGA adapter plus background ROMs.

## Interface
Parameters:
- `WIDTH`, default 320: screen width in pixels.
- `HEIGHT`, default 240: screen height in pixels.
- `ADDR_W`, default 17: ROM address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT.
- `COLOUR_W`, default 3: pixel colour width.
- `KEY_COLOUR`, default 0: transparent colour code, used only under `REDRAW_SKIP_KEY_EN`.

Ports (clock and reset first):
- `clock`  in  1: system clock. The block has one clock.
- `resetn`  in  1: reset, synchronous and active-low.
- `gameState`  in  4: current game state from the game-state controller.
- `romData`  in  COLOUR_W: ROM read data, valid one cycle after `romAddr`.
- `romAddr`  out  ADDR_W: ROM read address, equal to y*WIDTH + x of the scan point.
- `romSel`  out  3: background image select.
- `x`  out  9: plot column.
- `y`  out  8: plot row.
- `colour`  out  COLOUR_W: plot colour.
- `writeEn`  out  1: plot strobe to the VGA adapter.
- `doneRedraw`  out  1: redraw complete, back to the game-state controller.

## Operation
Redraw codes on `gameState`:
- 4'd10 DRAW_INITIAL → `romSel`=0.
- 4'd1 UPDATE_BRIDGE_1 → `romSel`=1.
- 4'd3 UPDATE_BRIDGE_2 → `romSel`=2.
- 4'd5 UPDATE_BRIDGE_3 → `romSel`=3.
- 4'd7 UPDATE_PILLAR → `romSel`=4.
- All other codes are non-redraw codes.

State machine:
- IDLE: if `gameState` is a redraw code, latch it into `reqState`, latch `romSel`, clear the scan counters, and go to SCAN.
- SCAN: issue one address per cycle, raster order, x fastest.
  - x wraps at WIDTH-1 to 0 and y increments.
  - After the address for (WIDTH-1, HEIGHT-1) is issued, go to DRAIN.
- DRAIN: one cycle, during which the last pixel is plotted. Then go to DONE.
- DONE: `doneRedraw`=1, held. When `gameState` ≠ `reqState`, deassert `doneRedraw` and go to IDLE.
- Abort: in SCAN or DRAIN, if `gameState` changes to a different redraw code, restart SCAN at (0,0) with the new select.
  - The pixel already in flight is still plotted.
- Non-redraw change during SCAN: if `gameState` changes to a non-redraw code, the sweep continues. Completion is then detected in DONE on the next cycle, and the block goes to IDLE.

Address and width rules:
- `romAddr` is kept as a separate incrementing counter, not computed by multiplication.
- `romAddr` resets to 0 at the start of each sweep.
- `romAddr` never exceeds WIDTH*HEIGHT-1.

Reset values (`resetn`=0 at a clock edge, including mid-sweep):
- State = IDLE.
- `x`, `y`, `romAddr`, `romSel` = 0.
- `colour` = 0, `writeEn` = 0, `doneRedraw` = 0.
- No partial plot is issued after reset.

## Timing
- Address for scan point (x,y) is driven in cycle n. In cycle n+1:
  - `x`/`y` show that point (registered delay of the counters).
  - `colour` = `romData`, combinational pass-through.
  - `writeEn` = 1.
- Trigger sampled at edge k, so SCAN starts cycle k+1.
  - Addresses issued in cycles k+1 … k+WIDTH*HEIGHT.
  - Last `writeEn` in cycle k+WIDTH*HEIGHT+1 (DRAIN).
  - `doneRedraw` first high in cycle k+WIDTH*HEIGHT+2.
- `writeEn` is high for exactly WIDTH*HEIGHT consecutive cycles per uninterrupted sweep, and low in IDLE and DONE.
- `doneRedraw` is a level signal, not a pulse. It is never high while `writeEn` is high.
- A redraw code that persists after DONE does not retrigger; a new redraw needs a code change first.

## Configuration
- Macro `REDRAW_SKIP_KEY_EN`.
- Defined: a pixel whose `romData` == KEY_COLOUR has `writeEn` forced to 0. Timing and pixel count are unchanged, and the framebuffer keeps its existing content at that pixel.
- Undefined: every pixel is written, and KEY_COLOUR is ignored.

## Test plan
All scenarios use WIDTH=4, HEIGHT=2, and a ROM model returning address[2:0].
- Reset then `gameState`=10 → `writeEn` high for 8 cycles; (x,y,colour) sequence (0,0,0)…(3,1,7); `romSel`=0; `doneRedraw` high 10 cycles after the trigger edge.
- `gameState` 0→1, held after done → single sweep with `romSel`=1; `doneRedraw` stays 1; after `gameState`=2, `doneRedraw`=0 next cycle and no new sweep.
- `gameState`=1, then switched to 3 on the 4th SCAN cycle → one more plot (x=3,y=0), then restart at (0,0) with `romSel`=2; total of 8 writes after the restart.
- `resetn`=0 mid-sweep at pixel 5 → next cycle all outputs 0 and state IDLE; with `gameState`=10 held, a full sweep restarts.
- With `REDRAW_SKIP_KEY_EN` and KEY_COLOUR=0 → 7 writes, address 0 skipped, `doneRedraw` timing unchanged.
- Without `REDRAW_SKIP_KEY_EN`, same stimulus → 8 writes.
